// File: rtl/trng_collector.sv
// trng_collector: samples the ring-generator serial bit and runs a repetition-count
// health test on the raw stream. Bits are optionally von Neumann debiased and then
// packed MSB-first into WIDTH-bit words. Words are handed out through a
// valid/read handshake, with the accumulator and the holding register acting as a
// two-deep buffer.
module trng_collector #(
   parameter int WIDTH     = 32,
   parameter int RCT_LIMIT = 32
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iEn,
   input  logic             iSerial,
   input  logic             iRawMode,
   input  logic             iRead,
   input  logic             iClrFail,
   output logic [WIDTH-1:0] oData,
   output logic             oValid,
   output logic             oFail
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [7:0] LIMIT = 8'(RCT_LIMIT);

   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic             phase;
   logic             aBit;
   logic             prev;
   logic             prevValid;
   logic             rawModeQ;
   logic [7:0]       run;

   logic       sample;
   logic       modeChg;
   logic       effPhase;
   logic       accept;
   logic       bitVal;
   logic       full;
   logic       xfer;
   logic [7:0] runNext;

   // Decode which bit (if any) is accepted this cycle and whether a word moves out.
   // A mode change is treated as if the pair phase were already back at 0, so a
   // half-collected pair from the old mode can never complete.
   always_comb begin
      sample   = iEn & ~oFail;
      modeChg  = iRawMode != rawModeQ;
      effPhase = modeChg ? 1'b0 : phase;
      accept   = sample & (iRawMode | (effPhase & (aBit != iSerial)));
      bitVal   = iRawMode ? iSerial : aBit;
      full     = count == CW'(WIDTH);
      xfer     = full & ~oFail & (~oValid | iRead);
      runNext  = run;
      if (!prevValid) begin
         runNext = 8'd1;
      end else if (iSerial == prev) begin
         runNext = (run == LIMIT) ? LIMIT : run + 8'd1;
      end else begin
         runNext = 8'd1;
      end
   end

   // Repetition-count health test; keeps running while failed so the run stays current.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oFail     <= 1'b0;
         run       <= 8'd0;
         prev      <= 1'b0;
         prevValid <= 1'b0;
      end else if (iClrFail) begin
         oFail     <= 1'b0;
         run       <= 8'd0;
         prevValid <= 1'b0;
      end else if (iEn) begin
         run       <= runNext;
         prev      <= iSerial;
         prevValid <= 1'b1;
         if (runNext == LIMIT) oFail <= 1'b1;
      end
   end

   // Von Neumann pair tracking and raw-mode change detection.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rawModeQ <= 1'b0;
         phase    <= 1'b0;
         aBit     <= 1'b0;
      end else begin
         rawModeQ <= iRawMode;
         if (iRawMode) begin
            phase <= 1'b0;
         end else if (sample) begin
            phase <= ~effPhase;
         end else begin
            phase <= effPhase;
         end
         if (sample & ~iRawMode & ~effPhase) aBit <= iSerial;
      end
   end

   // Accumulator: shift in accepted bits; a bit arriving on a transfer starts the next word.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         acc   <= '0;
         count <= '0;
      end else if (oFail) begin
         acc   <= '0;
         count <= '0;
      end else if (xfer) begin
         acc   <= WIDTH'(accept & bitVal);
         count <= CW'(accept);
      end else if (accept & ~full) begin
         acc   <= {acc[WIDTH-2:0], bitVal};
         count <= count + CW'(1);
      end
   end

   // Holding register and valid flag for the read handshake.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oData  <= '0;
         oValid <= 1'b0;
      end else if (xfer) begin
         oData  <= acc;
         oValid <= 1'b1;
      end else if (iRead & oValid) begin
         oValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: directed scenarios with random data words, checked every
// cycle against a queue-based reference model of the collector.
module tb_trng_collector;

   localparam int W   = 32;
   localparam int LIM = 32;

   logic         iClk = 1'b0;
   logic         iRst;
   logic         iEn;
   logic         iSerial;
   logic         iRawMode;
   logic         iRead;
   logic         iClrFail;
   logic [W-1:0] oData;
   logic         oValid;
   logic         oFail;

   trng_collector #(.WIDTH(W), .RCT_LIMIT(LIM)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iSerial(iSerial), .iRawMode(iRawMode),
      .iRead(iRead), .iClrFail(iClrFail), .oData(oData), .oValid(oValid), .oFail(oFail)
   );

   // Free-running clock.
   always #5 iClk = ~iClk;

   int nChecks = 0;
   int nErrors = 0;

   bit           mFail, mPrevValid, mPrev, mPhase, mA, mLastRaw, mHoldValid;
   int           mRun;
   logic [W-1:0] mHold;
   bit           accQ[$];
   bit           curRaw;

   function automatic void modelReset();
      mFail = 0; mPrevValid = 0; mPrev = 0; mPhase = 0; mA = 0; mLastRaw = 0;
      mHoldValid = 0; mRun = 0; mHold = '0;
      accQ.delete();
   endfunction

   function automatic logic [W-1:0] packQ();
      logic [W-1:0] wv = '0;
      foreach (accQ[i]) wv[W-1-i] = accQ[i];
      return wv;
   endfunction

   function automatic logic [W-1:0] safeWord();
      return ($urandom & ~32'h3) | 32'h1;
   endfunction

   task automatic chkWord(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkBit(input string tag, input logic obs, input logic exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input bit en, input bit ser, input bit raw, input bit rd, input bit clr);
      bit sample, ph, ok, b, full, xfer, oldFail;
      iEn = en; iSerial = ser; iRawMode = raw; iRead = rd; iClrFail = clr;
      oldFail = mFail;
      sample  = en && !mFail;
      ph      = (raw != mLastRaw) ? 1'b0 : mPhase;
      ok      = sample && (raw || (ph && (mA != ser)));
      b       = raw ? ser : mA;
      full    = accQ.size() == W;
      xfer    = full && !mFail && (!mHoldValid || rd);
      @(posedge iClk);
      #1;
      if (oldFail) begin
         accQ.delete();
      end else if (xfer) begin
         mHold = packQ();
         mHoldValid = 1;
         accQ.delete();
         if (ok) accQ.push_back(b);
      end else if (ok && !full) begin
         accQ.push_back(b);
      end
      if (!xfer && rd && mHoldValid) mHoldValid = 0;
      if (raw) mPhase = 0;
      else mPhase = sample ? !ph : ph;
      if (sample && !raw && !ph) mA = ser;
      mLastRaw = raw;
      if (clr) begin
         mFail = 0; mRun = 0; mPrevValid = 0;
      end else if (en) begin
         if (!mPrevValid) mRun = 1;
         else if (ser == mPrev) mRun = (mRun < LIM) ? mRun + 1 : LIM;
         else mRun = 1;
         mPrev = ser;
         mPrevValid = 1;
         if (mRun == LIM) mFail = 1;
      end
      chkWord("oData", oData, mHold);
      chkBit("oValid", oValid, mHoldValid);
      chkBit("oFail", oFail, mFail);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1'($urandom), curRaw, 0, 0);
   endtask

   task automatic readStep();
      step(0, 1'($urandom), curRaw, 1, 0);
   endtask

   task automatic sendWord(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) step(1, w[i], 1, 0, 0);
   endtask

   task automatic sendPair(input bit a, input bit b);
      step(1, a, 0, 0, 0);
      step(1, b, 0, 0, 0);
   endtask

   initial begin
      logic [W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9, v, expW;
      bit pairs [5][2];
      int acceptedCnt, k;

      // reset state
      iRst = 1; iEn = 0; iSerial = 0; iRawMode = 0; iRead = 0; iClrFail = 0;
      curRaw = 0;
      modelReset();
      #12;
      chkWord("rstData", oData, '0);
      chkBit("rstValid", oValid, 1'b0);
      chkBit("rstFail", oFail, 1'b0);
      iRst = 0;

      // raw word with latency check
      curRaw = 1;
      sendWord(32'hA5A5A5A5);
      chkBit("rawLatN1", oValid, 1'b0);
      idle(1);
      chkBit("rawLatN2", oValid, 1'b1);
      chkWord("rawWord", oData, 32'hA5A5A5A5);
      readStep();
      chkBit("rawRead", oValid, 1'b0);

      // debias with an iEn gap in the middle of a 10 pair
      curRaw = 0;
      pairs = '{'{1, 0}, '{0, 1}, '{0, 0}, '{1, 1}, '{1, 0}};
      acceptedCnt = 0;
      k = 0;
      while (acceptedCnt < W) begin
         step(1, pairs[k % 5][0], 0, 0, 0);
         if (k == 5) idle(3);
         step(1, pairs[k % 5][1], 0, 0, 0);
         if (pairs[k % 5][0] != pairs[k % 5][1]) acceptedCnt++;
         k++;
      end
      for (int i = 0; i < W; i++) expW[W-1-i] = (i % 3 == 1) ? 1'b0 : 1'b1;
      idle(2);
      chkWord("debiasWord", oData, expW);
      readStep();

      // back-to-back words, read in the transfer cycle
      curRaw = 1;
      w1 = safeWord(); w2 = safeWord();
      sendWord(w1);
      sendWord(w2);
      chkWord("b2bWord1", oData, w1);
      readStep();
      chkBit("b2bValid", oValid, 1'b1);
      chkWord("b2bWord2", oData, w2);
      readStep();

      // no reads for three words: second parked, third dropped
      w3 = safeWord(); w4 = safeWord(); w5 = safeWord();
      sendWord(w3); sendWord(w4); sendWord(w5);
      idle(2);
      chkWord("holdWord3", oData, w3);
      readStep();
      chkWord("parkedWord4", oData, w4);
      chkBit("parkedValid", oValid, 1'b1);
      readStep();
      idle(3);
      chkBit("word5Dropped", oValid, 1'b0);

      // health test: 31 identical bits pass, the 32nd fails
      w6 = safeWord();
      sendWord(w6);
      idle(2);
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < LIM - 1; i++) step(1, 1, 1, 0, 0);
      chkBit("run31NoFail", oFail, 1'b0);
      step(1, 1, 1, 0, 0);
      chkBit("run32Fail", oFail, 1'b1);
      idle(1);
      chkWord("heldAfterFail", oData, w6);
      readStep();
      chkBit("readDuringFail", oValid, 1'b0);
      step(0, 0, 1, 0, 1);
      chkBit("clrFail", oFail, 1'b0);
      w7 = safeWord();
      sendWord(w7);
      idle(2);
      chkWord("afterClrWord", oData, w7);
      readStep();

      // asynchronous reset mid-word with a held word
      w8 = safeWord(); w9 = safeWord();
      sendWord(w8);
      idle(2);
      for (int i = W - 1; i >= W - 17; i--) step(1, w9[i] ^ 1'b1, 1, 0, 0);
      #3 iRst = 1;
      #1;
      chkBit("asyncRstValid", oValid, 1'b0);
      chkWord("asyncRstData", oData, '0);
      chkBit("asyncRstFail", oFail, 1'b0);
      #1 iRst = 0;
      modelReset();
      sendWord(w9);
      idle(2);
      chkWord("postRstWord", oData, w9);
      readStep();
      idle(40);
      chkBit("postRstOneWord", oValid, 1'b0);

      // raw-mode toggle discards a pending phase-0 bit
      curRaw = 0;
      sendPair(1, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      v = safeWord();
      v[W-2] = 1'b0;
      for (int i = W - 2; i >= 0; i--) sendPair(v[i], !v[i]);
      idle(2);
      expW = {1'b1, v[W-2:0]};
      chkWord("toggleWord", oData, expW);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/trng_collector.md
# trng_collector

Post-processing and word-assembly stage placed directly downstream of the 16-bit ring-generator entropy source. It samples the generator's serial output bit every enabled cycle and runs a repetition-count health test on the raw stream. Bits are optionally debiased with a von Neumann corrector, then packed into WIDTH-bit words. Completed words are presented to the peripheral register interface through a valid/read handshake backed by a two-deep buffer (accumulator plus holding register).

## Interface
- WIDTH, 32: output word width in bits (≥2).
- RCT_LIMIT, 32: run length of identical raw bits that declares a health failure (2..255).
- iClk  input  1  clock; all state updates on its rising edge.
- iRst  input  1  reset, asynchronous, active-high; clears all state immediately.
- iEn  input  1  sample enable, tied to the same enable driving the ring generator.
- iSerial  input  1  raw entropy bit from the ring generator's serial output.
- iRawMode  input  1  1 = bypass the von Neumann corrector; 0 = debias.
- iRead  input  1  consume the current word; meaningful only while oValid=1.
- iClrFail  input  1  clears oFail and restarts the health test.
- oData  output  WIDTH  holding-register word.
- oValid  output  1  oData holds an unread word.
- oFail  output  1  sticky health-test failure.

## Operation
- Reset values: oData=0, oValid=0, oFail=0, accumulator=0, bit count=0, pair phase=0, run count=0, previous-bit-valid flag=0.
- A sample cycle is any cycle with iEn=1 and oFail=0. When iEn=0, all state holds and nothing is discarded.
- Health test (repetition count) runs on every cycle with iEn=1, including while oFail=1:
  - The first sample after reset or iClrFail sets run=1 and stores prev=iSerial.
  - After that: if iSerial==prev, run increments, saturating at RCT_LIMIT; otherwise run=1. prev updates to iSerial.
  - When run reaches RCT_LIMIT, oFail sets on that edge.
  - iClrFail=1 clears oFail, run and the prev-valid flag on the next edge. iClrFail has priority over a same-cycle failure.
- While oFail=1, the accumulator and bit count are cleared and no bits are accepted. oData and oValid are unaffected, so a word already held can still be read.
- Raw mode: every sample cycle yields one accepted bit equal to iSerial.
- Debias mode: sample cycles alternate between pair phase 0 and pair phase 1.
  - Phase 0 stores a=iSerial.
  - Phase 1 compares b=iSerial with a: (a,b)=(1,0) accepts bit 1; (0,1) accepts bit 0; 00 and 11 accept nothing.
  - Phase toggles on every sample cycle.
- A change of iRawMode, detected against a registered copy, clears the pair phase to 0. Partial accumulator contents are kept.
- Packing: an accepted bit shifts in as acc <= {acc[WIDTH-2:0], bit}, and count increments. The first accepted bit ends in oData[WIDTH-1].
- The accumulator is full when count==WIDTH. While full and not transferring, accepted bits are dropped.
- Transfer happens in any cycle where the accumulator is full and the holding register is free, i.e. oValid=0, or oValid=1 with iRead=1. On that edge: oData<=acc, oValid<=1, count<=0. A bit accepted in the same cycle becomes bit 0 of the new accumulator (count=1).
- iRead with oValid=1 and no transfer: oValid<=0 and oData holds its value. iRead with oValid=0 is ignored.
- Maximum throughput is one word per WIDTH sample cycles in raw mode, with no bubble between consecutive words.

## Timing
- Raw mode latency: the WIDTH-th accepted bit sampled in cycle N fills the accumulator at edge N. The transfer occurs at edge N+1, so oValid=1 in cycle N+2.
- Debias mode: the bit is decided at the phase-1 sample. The same N/N+1/N+2 timing applies from that cycle.
- Failure: the RCT_LIMIT-th identical sample in cycle N sets oFail at edge N. Bits from cycle N+1 onward are blocked.
- iRst asserted mid-word or mid-pair: everything returns to reset values asynchronously. The first accepted bit after release starts a new word at count 0.

## Test plan
- Raw mode, WIDTH=32, stream 0xA5A5A5A5 MSB-first over 32 enabled cycles -> oData=0xA5A5A5A5, with oValid rising 2 cycles after the last bit.
- Debias mode, pairs 10,01,00,11,10 repeated until 32 accepted bits -> word contains the pattern 1,0,1 repeated; 00 and 11 pairs add nothing. Dropping iEn mid-pair and resuming keeps the pair intact.
- Back-to-back raw words with iRead pulsed in the transfer cycle -> oValid stays 1 and oData switches to word 2 with no gap. Holding iRead low for 3 words -> word 2 is parked in the accumulator, word 3's bits are dropped, and a later read delivers word 2.
- RCT_LIMIT=32, 32 consecutive 1s -> oFail=1 at the 32nd sample and the accumulator is cleared. A held word remains readable. iClrFail then restarts collection from count 0. A run of 31 identical bits leaves oFail=0.
- iRst pulsed asynchronously between clock edges with 17 bits collected and oValid=1 -> oValid=0, oData=0 and oFail=0 immediately. After release, 32 fresh bits produce exactly one word.
- Toggling iRawMode after a phase-0 sample -> the pending bit is discarded (phase cleared) and the accumulator count is unchanged.
